serial_add_accum: RTL and testbench

//   Bit-serial adder/subtractor/accumulator. Consumes two WIDTH-bit operands LSB first, one bit
//   per enabled clock, and emits the sum serially with carry, signed-overflow and zero flags.

---
 rtl/serial_alu_pkg.sv | 17 +
 rtl/serial_add_accum_if.sv | 31 +++
 rtl/serial_add_accum_core.sv | 140 ++++++++++++++
 rtl/serial_fa_cell.sv | 36 +++
 rtl/serial_add_accum.sv | 33 +++
 tb/tb_serial_add_accum.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - mode and FSM state encodings for the bit-serial adder/accumulator
package serial_alu_pkg;

    // Frame operation, latched with the first bit of each frame
    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_SUB   = 2'b01,
        MODE_ACC   = 2'b10,
        MODE_CHAIN = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/serial_add_accum_if.sv
// rtl/serial_add_accum_if.sv - decoded bit-stream and status signals of the serial adder
// Stimulus: a_bit, b_bit, start, mode, valid.
// Status:   sum_bit, sum_valid, carry_out, overflow, done, busy, zero, frame_err.
interface serial_add_accum_if;

    logic       a_bit;
    logic       b_bit;
    logic       start;
    logic [1:0] mode;
    logic       valid;

    logic       sum_bit;
    logic       sum_valid;
    logic       carry_out;
    logic       overflow;
    logic       done;
    logic       busy;
    logic       zero;
    logic       frame_err;

    modport master (
        output a_bit, b_bit, start, mode, valid,
        input  sum_bit, sum_valid, carry_out, overflow, done, busy, zero, frame_err
    );

    modport slave (
        input  a_bit, b_bit, start, mode, valid,
        output sum_bit, sum_valid, carry_out, overflow, done, busy, zero, frame_err
    );

endinterface

// File: rtl/serial_add_accum_core.sv
// rtl/serial_add_accum_core.sv - FSM, bit counter, accumulator and flags of the serial adder
// Ports: clk, rst_n (async, active-low), bus (slave side of serial_add_accum_if).
module serial_add_accum_core
    import serial_alu_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_accum_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mode_e              mode_q, mode_eff;
    logic [WIDTH-1:0]   acc_q, acc_shadow_q, acc_base;
    logic               chain_c_q, carry_q, ovf_q, zero_q, zero_or_q, ferr_q;
    logic               sum_valid_q, done_q;
    logic               is_first, consume, abort, is_msb;
    logic               y, cin_init, ci, s_d, co_d, s_q;

    // A start with valid always opens a frame; in RUN it also kills the current one.
    assign is_first = bus.valid & bus.start;
    assign consume  = bus.valid & (bus.start | (state_q == ST_RUN));
    assign abort    = is_first & (state_q == ST_RUN);
    assign is_msb   = consume & ~bus.start & (state_q == ST_RUN)
                    & (cnt_q == CNT_W'(WIDTH - 1));
    assign mode_eff = is_first ? mode_e'(bus.mode) : mode_q;
    // On abort the new frame must start from the accumulator as it was before the
    // aborted frame began shifting it.
    assign acc_base = abort ? acc_shadow_q : acc_q;

    always_comb begin
        y        = bus.b_bit;
        cin_init = 1'b0;
        case (mode_eff)
            MODE_SUB: begin
                y        = ~bus.b_bit;
                cin_init = 1'b1;
            end
            MODE_ACC:   y = acc_base[0];
            // An abort clears the chain carry before the replacement frame uses it.
            MODE_CHAIN: cin_init = abort ? 1'b0 : chain_c_q;
            default: ;
        endcase
    end

    serial_fa_cell u_fa (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (consume),
        .x        (bus.a_bit),
        .y        (y),
        .cin_init (cin_init),
        .cin_sel  (is_first),
        .ci       (ci),
        .s_d      (s_d),
        .co_d     (co_d),
        .s_q      (s_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (is_first) begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(1);
        end else if (is_msb) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (consume) begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_ADD;
            acc_q        <= ACC_INIT;
            acc_shadow_q <= ACC_INIT;
            chain_c_q    <= 1'b0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
            zero_or_q    <= 1'b0;
            ferr_q       <= 1'b0;
            sum_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sum_valid_q <= consume;
            done_q      <= is_msb;
            if (is_first) begin
                mode_q       <= mode_e'(bus.mode);
                acc_shadow_q <= acc_base;
            end
            if (consume) begin
                if (mode_eff == MODE_ACC) begin
                    acc_q <= {s_d, acc_base[WIDTH-1:1]};
                end else begin
                    acc_q <= acc_base;
                end
                zero_or_q <= is_first ? s_d : (zero_or_q | s_d);
            end
            if (abort) begin
                ferr_q    <= 1'b1;
                chain_c_q <= 1'b0;
            end
            if (is_msb) begin
                carry_q   <= co_d;
                ovf_q     <= ci ^ co_d;
                zero_q    <= ~(zero_or_q | s_d);
                chain_c_q <= co_d;
                ferr_q    <= 1'b0;
            end
        end
    end

    assign bus.sum_bit   = s_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.zero      = zero_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - registered one-bit full adder with selectable carry-in
// Ports: clk, rst_n (async, active-low), en (consume bit), x, y operand bits,
//        cin_init/cin_sel (frame carry-in replaces the running carry when cin_sel=1),
//        ci/s_d/co_d combinational carry-in, sum and carry-out of the current bit,
//        s_q registered sum of the last consumed bit.
module serial_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic x,
    input  logic y,
    input  logic cin_init,
    input  logic cin_sel,
    output logic ci,
    output logic s_d,
    output logic co_d,
    output logic s_q
);

    logic c_q;

    assign ci   = cin_sel ? cin_init : c_q;
    assign s_d  = x ^ y ^ ci;
    assign co_d = (x & y) | (x & ci) | (y & ci);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
            c_q <= 1'b0;
        end else if (en) begin
            s_q <= s_d;
            c_q <= co_d;
        end
    end

endmodule

// File: rtl/serial_add_accum.sv
// rtl/serial_add_accum.sv - bit-serial add/sub/accumulate/chain unit on 8-bit user pins
// io_in:  [0] clk, [1] rst_n, [2] a_bit, [3] b_bit, [4] start, [6:5] mode, [7] valid
// io_out: [0] sum_bit, [1] sum_valid, [2] carry_out, [3] overflow, [4] done,
//         [5] busy, [6] zero, [7] frame_err
module serial_add_accum #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    serial_add_accum_if u_bus ();

    assign u_bus.a_bit = io_in[2];
    assign u_bus.b_bit = io_in[3];
    assign u_bus.start = io_in[4];
    assign u_bus.mode  = io_in[6:5];
    assign u_bus.valid = io_in[7];

    serial_add_accum_core #(
        .WIDTH    (WIDTH),
        .ACC_INIT (ACC_INIT)
    ) u_core (
        .clk   (io_in[0]),
        .rst_n (io_in[1]),
        .bus   (u_bus.slave)
    );

    assign io_out = {u_bus.frame_err, u_bus.zero, u_bus.busy, u_bus.done,
                     u_bus.overflow, u_bus.carry_out, u_bus.sum_valid, u_bus.sum_bit};

endmodule

// File: tb/tb_serial_add_accum.sv
// tb/tb_serial_add_accum.sv - scoreboard bench for serial_add_accum at WIDTH=8
module tb_serial_add_accum;
    import serial_alu_pkg::*;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    serial_add_accum_if bus ();

    assign io_in = {bus.valid, bus.mode, bus.start, bus.b_bit, bus.a_bit, rst_n, clk};
    assign bus.sum_bit   = io_out[0];
    assign bus.sum_valid = io_out[1];
    assign bus.carry_out = io_out[2];
    assign bus.overflow  = io_out[3];
    assign bus.done      = io_out[4];
    assign bus.busy      = io_out[5];
    assign bus.zero      = io_out[6];
    assign bus.frame_err = io_out[7];

    serial_add_accum #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    exp_t       exp_q[$];
    logic [7:0] sum_sr = 8'h00;
    logic [7:0] m_acc  = 8'h00;
    logic       m_chain = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        logic       cin;
        logic [8:0] r;
        exp_t       e;
        y   = (m == MODE_SUB) ? ~b : (m == MODE_ACC) ? m_acc : b;
        cin = (m == MODE_SUB) ? 1'b1 : (m == MODE_CHAIN) ? m_chain : 1'b0;
        r   = {1'b0, a} + {1'b0, y} + {8'b0, cin};
        e.sum   = r[7:0];
        e.carry = r[8];
        e.ovf   = (a[7] == y[7]) && (r[7] != a[7]);
        e.zero  = (r[7:0] == 8'h00);
        return e;
    endfunction

    // Output monitor: collects serial sum bits and scores each completed frame.
    always @(negedge clk) begin
        exp_t e;
        if (bus.sum_valid === 1'b1) sum_sr = {bus.sum_bit, sum_sr[7:1]};
        if (bus.done === 1'b1) begin
            check("done_with_msb_valid", bus.sum_valid, 1);
            check("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sum", sum_sr, e.sum);
                check("carry_out", bus.carry_out, e.carry);
                check("overflow", bus.overflow, e.ovf);
                check("zero", bus.zero, e.zero);
            end
        end
    end

    task automatic cyc(input logic v, input logic s, input logic [1:0] m,
                       input logic a, input logic b);
        bus.valid = v;
        bus.start = s;
        bus.mode  = m;
        bus.a_bit = a;
        bus.b_bit = b;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, MODE_ADD, 1'b0, 1'b0);
    endtask

    task automatic bits(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                        input int lo, input int hi);
        for (int i = lo; i <= hi; i++) cyc(1'b1, i == 0, m, a[i], b[i]);
    endtask

    task automatic expect_frame(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e = model(m, a, b);
        exp_q.push_back(e);
        if (m == MODE_ACC) m_acc = e.sum;
        m_chain = e.carry;
    endtask

    task automatic frame(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        expect_frame(m, a, b);
        bits(m, a, b, 0, 7);
        check("done_pulse", bus.done, 1);
        idle();
        check("done_one_cycle", bus.done, 0);
        check("busy_after_frame", bus.busy, 0);
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.a_bit = 1'b0;
        bus.b_bit = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", io_out, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Accumulate 0x40 four times from reset: 40, 80, C0, 00.
        for (int k = 0; k < 4; k++) frame(MODE_ACC, 8'h40, 8'h00);
        check("acc4_zero", bus.zero, 1);
        check("acc4_carry", bus.carry_out, 1);

        frame(MODE_ADD, 8'h5A, 8'h3C);
        check("add_5a_3c_ovf", bus.overflow, 1);
        check("add_5a_3c_carry", bus.carry_out, 0);

        frame(MODE_SUB, 8'h10, 8'h10);
        check("sub_zero", bus.zero, 1);
        check("sub_no_borrow", bus.carry_out, 1);

        // Back-to-back ADD FF+01 then CHAIN 00+00 picks up the carry.
        expect_frame(MODE_ADD, 8'hFF, 8'h01);
        bits(MODE_ADD, 8'hFF, 8'h01, 0, 7);
        expect_frame(MODE_CHAIN, 8'h00, 8'h00);
        bits(MODE_CHAIN, 8'h00, 8'h00, 0, 7);
        check("chain_done", bus.done, 1);
        idle();

        // Aborting a frame with a CHAIN start drops the pending chain carry.
        frame(MODE_ADD, 8'hFF, 8'h01);
        bits(MODE_ADD, 8'h00, 8'h00, 0, 2);
        m_chain = 1'b0;
        expect_frame(MODE_CHAIN, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, MODE_CHAIN, 1'b0, 1'b0);
        check("chain_abort_ferr", bus.frame_err, 1);
        bits(MODE_CHAIN, 8'h00, 8'h00, 1, 7);
        idle();

        // Stall of three cycles after bit 3.
        expect_frame(MODE_ADD, 8'h12, 8'h34);
        bits(MODE_ADD, 8'h12, 8'h34, 0, 3);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, MODE_ADD, 1'b1, 1'b1);
            check("stall_busy", bus.busy, 1);
            check("stall_no_valid", bus.sum_valid, 0);
        end
        bits(MODE_ADD, 8'h12, 8'h34, 4, 7);
        idle();

        // Abort at bit 4 by a new 0x01+0x01 frame.
        bits(MODE_ADD, 8'h12, 8'h34, 0, 3);
        m_chain = 1'b0;
        expect_frame(MODE_ADD, 8'h01, 8'h01);
        cyc(1'b1, 1'b1, MODE_ADD, 1'b1, 1'b1);
        check("abort_ferr_set", bus.frame_err, 1);
        check("abort_busy", bus.busy, 1);
        bits(MODE_ADD, 8'h01, 8'h01, 1, 7);
        check("abort_ferr_clear", bus.frame_err, 0);
        idle();

        // Asynchronous reset in the middle of an ACC frame.
        frame(MODE_ACC, 8'h33, 8'h00);
        bits(MODE_ACC, 8'hFF, 8'h00, 0, 2);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", io_out, 8'h00);
        @(negedge clk);
        check("reset_held_outputs", io_out, 8'h00);
        rst_n   = 1'b1;
        m_acc   = 8'h00;
        m_chain = 1'b0;
        @(negedge clk);
        frame(MODE_ACC, 8'h05, 8'h00);
        frame(MODE_CHAIN, 8'h0F, 8'hF1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
